// File: rtl/nibble_serial_subtractor_ctrl_if.sv
// Handshake and data bundle for the nibble-serial subtractor.
//   master: requester drives start/A/B/Bin and observes busy/done/D/Bout/zero
//   slave : the subtractor, which drives the status and result signals
interface nibble_serial_subtractor_ctrl_if #(
  parameter int unsigned NIBBLES = 4
);
  localparam int unsigned W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] D;
  logic         Bout;
  logic         zero;

  modport master (
    output start, A, B, Bin,
    input  busy, done, D, Bout, zero
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, D, Bout, zero
  );
endinterface

// File: rtl/nibble_serial_subtractor_ctrl.sv
// Wide subtractor D = A - B - Bin built from one shared 4-bit borrow stage,
// one nibble per clock, LSB nibble first.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of nibble_serial_subtractor_ctrl_if
//           (start/A/B/Bin in; busy/done/D/Bout/zero out, all registered)
module nibble_serial_subtractor_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  nibble_serial_subtractor_ctrl_if.slave  bus
);
  localparam int unsigned W    = 4 * NIBBLES;
  localparam int unsigned IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q;
  logic [W-1:0]      a_q;
  logic [W-1:0]      b_q;
  logic [W-1:0]      d_q;
  logic [IDXW-1:0]   idx_q;
  logic              borrow_q;
  logic              busy_q;
  logic              done_q;
  logic              bout_q;
  logic              zero_q;

  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [4:0]        diff;
  logic [W-1:0]      d_d;
  logic              last;

  // Shared nibble stage; borrow_q holds the captured Bin for nibble 0.
  always_comb begin
    nib_a = 4'(a_q >> {idx_q, 2'b00});
    nib_b = 4'(b_q >> {idx_q, 2'b00});
    diff  = 5'(nib_a) - 5'(nib_b) - 5'(borrow_q);
    d_d   = d_q;
    d_d[{idx_q, 2'b00} +: 4] = diff[3:0];
    last  = (idx_q == IDXW'(NIBBLES - 1));
  end

  // Sequencer with registered status and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q      <= bus.A;
            b_q      <= bus.B;
            borrow_q <= bus.Bin;
            d_q      <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
          end
        end
        S_RUN: begin
          d_q      <= d_d;
          borrow_q <= diff[4];
          if (last) begin
            // zero must see the nibble written this cycle, so use d_d.
            bout_q  <= diff[4];
            zero_q  <= (d_d == '0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + IDXW'(1);
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.zero = zero_q;
endmodule
